// File: rtl/coproc0.sv
// CP0 system-control coprocessor: SR/Cause/EPC/PRId registers, interrupt and
// exception entry, mtc0 writes and eret EXL clear.
module coproc0 (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        intReq,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    localparam logic [4:0]  ADDR_SR    = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE = 5'd13;
    localparam logic [4:0]  ADDR_EPC   = 5'd14;
    localparam logic [4:0]  ADDR_PRID  = 5'd15;
    localparam logic [31:0] PRID_VALUE = 32'h0000_2023;

    // Return address for the faulting instruction; a delay-slot instruction
    // restarts at its branch, one word earlier (wraps modulo 2^32).
    function automatic logic [31:0] excReturnPc(input logic [31:0] pc, input logic inDelay);
        logic [31:0] aligned;
        aligned = {pc[31:2], 2'b00};
        return inDelay ? (aligned - 32'd4) : aligned;
    endfunction

    logic [5:0]  srIm;
    logic        srExl;
    logic        srIe;
    logic        causeBd;
    logic [5:0]  causeIp;
    logic [4:0]  causeExcCode;
    logic [31:0] epc;

    logic        intPend;
    logic        excPend;
    logic [31:0] srWord;
    logic [31:0] causeWord;
    logic [31:0] epcWord;

    // Register views; while reset is held they read as the cleared state.
    always_comb begin
        srWord    = 32'd0;
        causeWord = 32'd0;
        epcWord   = 32'd0;
        if (!reset) begin
            srWord    = {16'd0, srIm, 8'd0, srExl, srIe};
            causeWord = {causeBd, 15'd0, causeIp, 3'd0, causeExcCode, 2'd0};
            epcWord   = epc;
        end else begin
            srWord    = 32'd0;
            causeWord = 32'd0;
            epcWord   = 32'd0;
        end
    end

    // Pending conditions and the same-cycle take-exception request.
    always_comb begin
        intPend = ~reset & (|(HWInt & srIm)) & srIe & ~srExl;
        excPend = ~reset & (ExcCodeIn != 5'd0) & ~srExl;
        intReq  = intPend | excPend;
        EPCOut  = epcWord;
    end

    // mfc0 read mux straight from register contents (no write bypass).
    always_comb begin
        DOut = 32'd0;
        case (A)
            ADDR_SR:    DOut = srWord;
            ADDR_CAUSE: DOut = causeWord;
            ADDR_EPC:   DOut = epcWord;
            ADDR_PRID:  DOut = PRID_VALUE;
            default:    DOut = 32'd0;
        endcase
    end

    // State update: exception entry beats mtc0 and eret; eret beats mtc0 EXL.
    always_ff @(posedge clk) begin
        if (reset) begin
            srIm         <= 6'd0;
            srExl        <= 1'b0;
            srIe         <= 1'b0;
            causeBd      <= 1'b0;
            causeIp      <= 6'd0;
            causeExcCode <= 5'd0;
            epc          <= 32'd0;
        end else begin
            causeIp <= HWInt;
            if (intReq) begin
                srExl        <= 1'b1;
                causeBd      <= BDIn;
                causeExcCode <= intPend ? 5'd0 : ExcCodeIn;
                epc          <= excReturnPc(VPC, BDIn);
            end else begin
                if (WE) begin
                    case (A)
                        ADDR_SR: begin
                            srIm  <= DIn[15:10];
                            srExl <= DIn[1];
                            srIe  <= DIn[0];
                        end
                        ADDR_EPC: epc <= {DIn[31:2], 2'b00};
                        default:  ;
                    endcase
                end
                if (EXLClr) begin
                    srExl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_coproc0.sv
// Randomized and directed bench for coproc0 against a word-level CP0 model.
module tb_coproc0;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        intReq;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    int nTotal = 0;
    int nBad   = 0;

    logic [31:0] mSr, mCause, mEpc;
    logic        obsReq;
    logic [31:0] obsEpc, obsDout;

    coproc0 dut (
        .clk(clk), .reset(reset), .A(A), .DIn(DIn), .WE(WE), .VPC(VPC),
        .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
        .intReq(intReq), .EPCOut(EPCOut), .DOut(DOut)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTotal++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        case (a)
            5'd12:   return mSr;
            5'd13:   return mCause;
            5'd14:   return mEpc;
            5'd15:   return 32'h0000_2023;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: drive at negedge, check combinational outputs, advance model at posedge.
    task automatic step(input logic rst, input logic we, input logic [4:0] a,
                        input logic [31:0] din, input logic [31:0] vpc, input logic bd,
                        input logic [4:0] exc, input logic [5:0] hw, input logic eclr);
        logic irq, expReq;
        logic [31:0] expEpc, expDout;
        @(negedge clk);
        reset = rst; WE = we; A = a; DIn = din; VPC = vpc; BDIn = bd;
        ExcCodeIn = exc; HWInt = hw; EXLClr = eclr;
        #1;
        if (rst) begin
            irq     = 1'b0;
            expReq  = 1'b0;
            expEpc  = 32'd0;
            expDout = (a == 5'd15) ? 32'h0000_2023 : 32'd0;
        end else begin
            irq     = ((hw & mSr[15:10]) != 6'd0) && mSr[0] && !mSr[1];
            expReq  = irq || ((exc != 5'd0) && !mSr[1]);
            expEpc  = mEpc;
            expDout = modelRead(a);
        end
        obsReq = intReq; obsEpc = EPCOut; obsDout = DOut;
        checkVal("intReq", {31'd0, obsReq}, {31'd0, expReq});
        checkVal("EPCOut", obsEpc, expEpc);
        checkVal("DOut", obsDout, expDout);
        @(posedge clk);
        if (rst) begin
            mSr = 32'd0; mCause = 32'd0; mEpc = 32'd0;
        end else begin
            mCause[15:10] = hw;
            if (expReq) begin
                mSr[1]       = 1'b1;
                mCause[31]   = bd;
                mCause[6:2]  = irq ? 5'd0 : exc;
                mEpc         = (vpc & 32'hFFFF_FFFC) - (bd ? 32'd4 : 32'd0);
            end else begin
                if (we && a == 5'd12) mSr = din & 32'h0000_FC03;
                if (we && a == 5'd14) mEpc = din & 32'hFFFF_FFFC;
                if (eclr) mSr[1] = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] rdin;
        logic [4:0]  ra;
        mSr = 32'd0; mCause = 32'd0; mEpc = 32'd0;

        // Reset state, PRId readable during reset.
        step(1'b1, 1'b0, 5'd15, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        checkVal("rst_prid", obsDout, 32'h0000_2023);
        step(1'b1, 1'b1, 5'd12, 32'hFFFF_FFFF, 32'h100, 1'b0, 5'd3, 6'h3F, 1'b1);
        checkVal("rst_req", {31'd0, obsReq}, 32'd0);

        // Interrupt entry.
        step(1'b0, 1'b1, 5'd12, 32'h0000_0401, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        step(1'b0, 1'b0, 5'd12, 32'd0, 32'h3010, 1'b0, 5'd0, 6'b000001, 1'b0);
        checkVal("irq_req", {31'd0, obsReq}, 32'd1);
        step(1'b0, 1'b0, 5'd14, 32'd0, 32'd0, 1'b0, 5'd0, 6'b000001, 1'b0);
        checkVal("irq_epc", obsDout, 32'h0000_3010);
        checkVal("irq_req_after", {31'd0, obsReq}, 32'd0);
        step(1'b0, 1'b0, 5'd13, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        checkVal("irq_exccode", {27'd0, obsDout[6:2]}, 32'd0);
        step(1'b0, 1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1);
        checkVal("irq_exl", {31'd0, obsDout[1]}, 32'd1);

        // Delay-slot exception.
        step(1'b0, 1'b0, 5'd12, 32'd0, 32'h3024, 1'b1, 5'd4, 6'd0, 1'b0);
        checkVal("ds_req", {31'd0, obsReq}, 32'd1);
        step(1'b0, 1'b0, 5'd14, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        checkVal("ds_epc", obsDout, 32'h0000_3020);
        step(1'b0, 1'b0, 5'd13, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1);
        checkVal("ds_cause", obsDout, 32'h8000_0010);

        // Interrupt beats exception; mtc0 EPC discarded.
        step(1'b0, 1'b1, 5'd14, 32'h1234, 32'h5000, 1'b0, 5'd10, 6'b000001, 1'b0);
        checkVal("pri_req", {31'd0, obsReq}, 32'd1);
        step(1'b0, 1'b0, 5'd13, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        checkVal("pri_exccode", {27'd0, obsDout[6:2]}, 32'd0);
        checkVal("pri_epc", obsEpc, 32'h0000_5000);

        // EXL blocks new requests until eret.
        step(1'b0, 1'b0, 5'd12, 32'd0, 32'h6000, 1'b0, 5'd12, 6'b000001, 1'b0);
        checkVal("exl_block", {31'd0, obsReq}, 32'd0);
        step(1'b0, 1'b0, 5'd12, 32'd0, 32'h6000, 1'b0, 5'd12, 6'b000001, 1'b1);
        checkVal("exl_clr_cycle", {31'd0, obsReq}, 32'd0);
        step(1'b0, 1'b0, 5'd12, 32'd0, 32'h6004, 1'b0, 5'd12, 6'b000001, 1'b0);
        checkVal("exl_after_clr", {31'd0, obsReq}, 32'd1);

        // Reset mid-handler, then reads.
        step(1'b1, 1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 6'b000001, 1'b0);
        step(1'b0, 1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 6'b000001, 1'b0);
        checkVal("mid_rst_req", {31'd0, obsReq}, 32'd0);
        checkVal("mid_rst_sr", obsDout, 32'd0);
        checkVal("mid_rst_epc", obsEpc, 32'd0);
        step(1'b0, 1'b0, 5'd15, 32'd0, 32'd0, 1'b0, 5'd0, 6'b100000, 1'b0);
        checkVal("rd_prid", obsDout, 32'h0000_2023);
        step(1'b0, 1'b0, 5'd13, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        checkVal("rd_ip15", {31'd0, obsDout[15]}, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            ra = ($urandom_range(0, 7) < 5) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
            rdin = $urandom;
            if ($urandom_range(0, 1) == 0) rdin[1] = 1'b0;
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), ra, rdin,
                 $urandom, 1'($urandom),
                 ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                 ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
                 ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
